// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, one result bit per cycle
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      Funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result
);

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              neg_q, neg_d;
  logic              spec_q, spec_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   res_q, res_d;

  logic              is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf, div_ge;
  logic [XLEN-1:0]   a_mag, b_mag, div_diff, div_sel, div_fix, spec_val;
  logic [XLEN:0]     mul_sum, div_shift;
  logic [2*XLEN-1:0] prod_fix;

  always_comb begin
    is_div   = Funct3[2];
    sgn_a    = (Funct3 == OP_MULH) || (Funct3 == OP_MULHSU) ||
               (Funct3 == OP_DIV)  || (Funct3 == OP_REM);
    sgn_b    = (Funct3 == OP_MULH) || (Funct3 == OP_DIV) || (Funct3 == OP_REM);
    a_neg    = sgn_a & SrcA[XLEN-1];
    b_neg    = sgn_b & SrcB[XLEN-1];
    a_mag    = a_neg ? -SrcA : SrcA;
    b_mag    = b_neg ? -SrcB : SrcB;
    div_zero = (SrcB == '0);
    div_ovf  = ((Funct3 == OP_DIV) || (Funct3 == OP_REM)) &&
               (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
    // Funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (div_zero) spec_val = Funct3[1] ? SrcA : '1;
    else          spec_val = Funct3[1] ? '0 : SrcA;

    mul_sum   = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_diff  = div_shift[XLEN-1:0] - opnd_q;

    prod_fix = neg_q ? -{acc_q, lo_q} : {acc_q, lo_q};
    div_sel  = op_q[1] ? acc_q : lo_q;
    div_fix  = neg_q ? -div_sel : div_sel;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
    spec_d  = spec_q;
    done_d  = 1'b0;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d   = Funct3;
          acc_d  = '0;
          cnt_d  = CNT_W'(XLEN - 1);
          spec_d = 1'b0;
          if (is_div) begin
            opnd_d = b_mag;
            lo_d   = a_mag;
            neg_d  = Funct3[1] ? a_neg : (a_neg ^ b_neg);
          end else begin
            opnd_d = a_mag;
            lo_d   = b_mag;
            neg_d  = a_neg ^ b_neg;
          end
          if (is_div && (div_zero || div_ovf)) begin
            spec_d  = 1'b1;
            lo_d    = spec_val;
            state_d = S_FIX;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (op_q[2]) begin
          acc_d = div_ge ? div_diff : div_shift[XLEN-1:0];
          lo_d  = {lo_q[XLEN-2:0], div_ge};
        end else begin
          acc_d = mul_sum[XLEN:1];
          lo_d  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) state_d = S_FIX;
      end
      S_FIX: begin
        if (spec_q)                 res_d = lo_q;
        else if (op_q[2])           res_d = div_fix;
        else if (op_q[1:0] == 2'b00) res_d = prod_fix[XLEN-1:0];
        else                        res_d = prod_fix[2*XLEN-1:XLEN];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // flush beats start and suppresses a pending result write
    if (flush) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign Result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - randomized self-checking bench for muldiv_unit (XLEN 32 and 8)
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, flush = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done;
  logic [31:0] res;

  logic        start8 = 1'b0, flush8 = 1'b0;
  logic [2:0]  f3_8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8;
  logic [7:0]  res8;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .Funct3(f3), .SrcA(a), .SrcB(b),
    .flush(flush), .busy(busy), .done(done), .Result(res)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .Funct3(f3_8), .SrcA(a8), .SrcB(b8),
    .flush(flush8), .busy(busy8), .done(done8), .Result(res8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference result from the RISC-V M-extension rules, using wide integer arithmetic
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a_in,
                                          input logic [31:0] b_in, input int w);
    logic signed [131:0] one, mask, ua, ub, sa, sb, r;
    logic ovf;
    one  = 132'sd1;
    mask = (one <<< w) - one;
    ua   = $signed({100'd0, a_in}) & mask;
    ub   = $signed({100'd0, b_in}) & mask;
    sa   = ua[w-1] ? ua - (one <<< w) : ua;
    sb   = ub[w-1] ? ub - (one <<< w) : ub;
    ovf  = (ua == (one <<< (w-1))) && (ub == mask);
    case (f)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: r = (ua * ub) >>> w;
      3'd4: r = (ub == 0) ? mask : ovf ? ua : sa / sb;
      3'd5: r = (ub == 0) ? mask : ua / ub;
      3'd6: r = (ub == 0) ? ua : ovf ? 0 : sa % sb;
      default: r = (ub == 0) ? ua : ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a_in,
                                 input logic [31:0] b_in, input int w);
    logic [31:0] m, am, bm;
    m  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    am = a_in & m;
    bm = b_in & m;
    if (f[2] && (bm == 0 || (!f[0] && am == (32'd1 << (w-1)) && bm == m))) return 1;
    return w + 1;
  endfunction

  // Protocol-level model of the 32-bit unit, checked every cycle
  bit          pending = 0;
  int          exp_done = 0;
  logic [31:0] exp_res = '0, last_res = '0;

  always @(negedge clk) begin
    bit exp_busy, exp_dn;
    if (reset) begin
      pending  = 0;
      last_res = '0;
    end else begin
      exp_busy = pending && (cyc < exp_done);
      exp_dn   = pending && (cyc == exp_done);
      chk("mon_busy", {31'd0, busy}, {31'd0, exp_busy});
      chk("mon_done", {31'd0, done}, {31'd0, exp_dn});
      if (exp_dn) begin
        last_res = exp_res;
        pending  = 0;
      end
      chk("mon_result", res, last_res);
      if (flush) pending = 0;
      else if (start && !exp_busy) begin
        pending  = 1;
        exp_done = cyc + 1 + ref_lat(f3, a, b, 32);
        exp_res  = ref_res(f3, a, b, 32);
      end
    end
  end

  // Called right after an edge (+1); issues one start pulse and scrambles inputs afterwards
  task automatic go32(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; f3 = f; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; f3 = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done32(output int lat);
    int t = 0;
    while (done !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 100) chk("done_timeout", {31'd0, done}, 32'd1);
    lat = t;
  endtask

  task automatic dir32(input string nm, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    go32(f, x, y);
    wait_done32(lat);
    chk({nm, "_res"}, res, exp);
    chk({nm, "_lat"}, lat, exp_lat);
  endtask

  task automatic idle_no_done(input string nm, input int n);
    int nd = 0;
    repeat (n) begin
      @(posedge clk); #1;
      if (done === 1'b1) nd++;
    end
    chk(nm, nd, 0);
  endtask

  task automatic run8(input logic [2:0] f, input logic [7:0] x, input logic [7:0] y);
    int t = 0;
    logic [31:0] exp;
    exp = ref_res(f, {24'd0, x}, {24'd0, y}, 8);
    start8 = 1'b1; f3_8 = f; a8 = x; b8 = y;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
    chk("x8_busy", {31'd0, busy8 | done8}, 32'd1);
    while (done8 !== 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("x8_res", {24'd0, res8}, exp);
    chk("x8_lat", t, ref_lat(f, {24'd0, x}, {24'd0, y}, 8));
  endtask

  initial begin
    int lat;
    logic [31:0] x, y;
    logic [2:0]  f;
    int mode;

    chk("model_mul", ref_res(3'd0, 32'd7, 32'hFFFF_FFFD, 32), 32'hFFFF_FFEB);
    chk("model_div", ref_res(3'd4, 32'hFFFF_FFF9, 32'd2, 32), 32'hFFFF_FFFD);
    chk("model_rem", ref_res(3'd6, 32'hFFFF_FFF9, 32'd2, 32), 32'hFFFF_FFFF);
    chk("model_mulhu8", ref_res(3'd3, 32'hFF, 32'hFF, 8), 32'hFE);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_res", res, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    dir32("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    dir32("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
    dir32("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    dir32("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    dir32("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    dir32("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    dir32("divu", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33);
    dir32("div0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    dir32("remu0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    dir32("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    dir32("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);

    // second start mid-operation is ignored
    go32(3'd4, 32'd100, 32'hFFFF_FFF9);
    repeat (8) begin @(posedge clk); #1; end
    start = 1'b1; f3 = 3'd0; a = 32'd3; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done32(lat);
    chk("ign_start_res", res, 32'hFFFF_FFF2);

    // flush mid-operation: no done, Result holds
    go32(3'd0, 32'd9, 32'd9);
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    idle_no_done("flush_no_done", 40);
    chk("flush_res", res, 32'hFFFF_FFF2);

    // flush wins over start in the same cycle
    start = 1'b1; flush = 1'b1; f3 = 3'd0; a = 32'd2; b = 32'd2;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_prio_busy", {31'd0, busy}, 32'd0);

    // start coincident with done
    go32(3'd5, 32'd100, 32'd7);
    wait_done32(lat);
    chk("b2b_first", res, 32'd14);
    go32(3'd0, 32'd6, 32'd7);
    wait_done32(lat);
    chk("b2b_res", res, 32'd42);
    chk("b2b_lat", lat, 33);

    // asynchronous reset mid-CALC
    go32(3'd0, 32'd7, 32'hFFFF_FFFD);
    repeat (5) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_res", res, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    idle_no_done("arst_no_done", 40);

    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom);
      x = $urandom;
      y = $urandom;
      mode = $urandom_range(0, 9);
      if (mode == 0) y = 32'd0;
      if (mode == 1) begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
      if (mode == 2) begin x = 32'($urandom_range(0, 20)); y = 32'($urandom_range(0, 5)); end
      go32(f, x, y);
      if (mode == 3) begin
        repeat ($urandom_range(0, 30)) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
      end else begin
        wait_done32(lat);
        chk("rand_res", res, ref_res(f, x, y, 32));
        chk("rand_lat", lat, ref_lat(f, x, y, 32));
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    run8(3'd3, 8'hFF, 8'hFF);
    run8(3'd4, 8'h80, 8'hFF);
    run8(3'd6, 8'hF9, 8'h02);
    for (int i = 0; i < 20; i++) begin
      y = $urandom;
      if (i % 5 == 0) y = 0;
      run8(3'($urandom), 8'($urandom), y[7:0]);
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
